// File: rtl/memory_responder_if.sv
// Request/response bundle between an initiator and memory_responder.
// The initiator drives the request fields; the responder returns read_data, valid and busy.
interface memory_responder_if;
  logic        enable;
  logic        command;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic [31:0] read_data;
  logic        valid;
  logic        busy;

  modport master (
    output enable, command, address, write_data, write_mask,
    input  read_data, valid, busy
  );

  modport slave (
    input  enable, command, address, write_data, write_mask,
    output read_data, valid, busy
  );
endinterface

// File: rtl/memory_responder.sv
// Single-port word-addressed RAM with a programmable response latency.
// One request is in flight at a time; completion is signalled by a one-cycle valid pulse.
module memory_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned LATENCY    = 1,
  parameter string       INIT_FILE  = ""
) (
  input  logic               clk,
  input  logic               reset,
  memory_responder_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  counter;
  logic        req_cmd;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic [31:0] read_data_q;
  logic [31:0] mem [DEPTH];

  logic                  acc_cmd;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_mask;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic                  access;
  logic                  unused_addr_bits;

  // NOTE: always_comb gives every output a default first so no path leaves one unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.enable) next_state = (LATENCY > 1) ? WAIT : RESP;
      WAIT:    if (counter == 4'd1) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With LATENCY=1 the accept edge is also the commit edge, so the operands come
  // straight from the bus; otherwise only the latched copy is used.
  always_comb begin
    acc_cmd   = req_cmd;
    acc_addr  = req_addr;
    acc_wdata = req_wdata;
    acc_mask  = req_mask;
    if (state == IDLE) begin
      acc_cmd   = bus.command;
      acc_addr  = bus.address;
      acc_wdata = bus.write_data;
      acc_mask  = bus.write_mask;
    end
  end

  assign idx              = acc_addr[ADDR_WIDTH+1:2];
  assign in_range         = (acc_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign access           = !reset && (next_state == RESP) && (state != RESP);
  assign unused_addr_bits = ^acc_addr[1:0];

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      req_cmd     <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      req_mask    <= '0;
      read_data_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && bus.enable) begin
        req_cmd   <= bus.command;
        req_addr  <= bus.address;
        req_wdata <= bus.write_data;
        req_mask  <= bus.write_mask;
        counter   <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        counter <= counter - 4'd1;
      end
      if (access && !acc_cmd) read_data_q <= in_range ? mem[idx] : 32'h0;
    end
  end

  // NOTE: the array is deliberately not reset; clearing it would need a per-word reset path.
  always_ff @(posedge clk) begin
    if (access && acc_cmd && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign bus.valid     = (state == RESP);
  assign bus.busy      = (state != IDLE);
  assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: a LATENCY=1 and a LATENCY=4 instance
// share one stimulus port; a scoreboard queue holds expected completions.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel4;
  logic        en;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        valid;
  logic        busy;
  logic [31:0] rdata;
  int          lat;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_responder_if bus1();
  memory_responder_if bus4();

  assign bus1.enable     = en & ~sel4;
  assign bus4.enable     = en & sel4;
  assign bus1.command    = cmd;
  assign bus4.command    = cmd;
  assign bus1.address    = addr;
  assign bus4.address    = addr;
  assign bus1.write_data = wdata;
  assign bus4.write_data = wdata;
  assign bus1.write_mask = mask;
  assign bus4.write_mask = mask;

  always_comb begin
    valid = sel4 ? bus4.valid     : bus1.valid;
    busy  = sel4 ? bus4.busy      : bus1.busy;
    rdata = sel4 ? bus4.read_data : bus1.read_data;
    lat   = sel4 ? 4 : 1;
  end

  memory_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  memory_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );

  // One complete transaction from a registered initiator: raise enable, wait for
  // valid, drop enable on the following edge, then confirm the pulse was single.
  task automatic req(input logic c, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic [31:0] exp_rd, input string name);
    bit   seen = 1'b0;
    exp_t e;
    @(posedge clk); #1;
    en = 1'b1; cmd = c; addr = a; wdata = d; mask = m;
    sb.push_back('{!c, exp_rd, cyc + lat});
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s: valid with empty scoreboard in cycle %0d", name, cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.due) begin
            errors++;
            $display("FAIL %s latency: valid in cycle %0d, required cycle %0d", name, cyc, e.due);
          end
          if (e.is_read) begin
            checks++;
            if (rdata !== e.data) begin
              errors++;
              $display("FAIL %s data: read_data %h, required %h", name, rdata, e.data);
            end
          end
        end
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout: no valid within 40 cycles", name);
      sb.delete();
    end
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after: valid %b busy %b, required 0 0", name, valid, busy);
    end
  endtask

  task automatic test_reset_state();
    reset = 1'b1; en = 1'b0; cmd = 1'b0; addr = '0; wdata = '0; mask = '0; sel4 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus1.valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_lat1: valid %b busy %b read_data %h, required 0 0 0",
               bus1.valid, bus1.busy, bus1.read_data);
    end
    checks++;
    if (bus4.valid !== 1'b0 || bus4.busy !== 1'b0 || bus4.read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_lat4: valid %b busy %b read_data %h, required 0 0 0",
               bus4.valid, bus4.busy, bus4.read_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_request();
    int a;
    int nvalid = 0;
    sel4 = 1'b1;
    req(1'b1, 32'h10, 32'h0102_0304, 4'b1111, 32'h0, "rst_prewrite");
    @(posedge clk); #1;
    en = 1'b1; cmd = 1'b1; addr = 32'h10; wdata = 32'hFFFF_FFFF; mask = 4'b1111;
    a = cyc;
    @(negedge clk);
    if (valid) nvalid++;
    @(posedge clk); #1;
    en = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_wait: busy %b in cycle %0d, required 1", busy, a + 1);
    end
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (valid) nvalid++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (valid) nvalid++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_after: busy %b, required 0", busy);
    end
    checks++;
    if (nvalid !== 0) begin
      errors++;
      $display("FAIL rst_no_valid: %0d valid pulses, required 0", nvalid);
    end
    req(1'b0, 32'h10, 32'h0, 4'b0000, 32'h0102_0304, "rst_readback");
  endtask

  task automatic test_latency1();
    sel4 = 1'b0;
    req(1'b1, 32'h4, 32'hDEAD_BEEF, 4'b1111, 32'h0,         "l1_write");
    req(1'b0, 32'h4, 32'h0,         4'b0000, 32'hDEAD_BEEF, "l1_read");
  endtask

  task automatic test_byte_mask();
    sel4 = 1'b0;
    req(1'b1, 32'h8, 32'h1122_3344, 4'b1111, 32'h0,         "mask_init");
    req(1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, 32'h0,         "mask_0101");
    req(1'b0, 32'h8, 32'h0,         4'b0000, 32'h11BB_33DD, "mask_read");
    req(1'b1, 32'h8, 32'h0,         4'b0000, 32'h0,         "mask_none");
    req(1'b0, 32'h8, 32'h0,         4'b0000, 32'h11BB_33DD, "mask_none_read");
  endtask

  task automatic test_out_of_range();
    sel4 = 1'b0;
    req(1'b1, 32'h0,    32'h0BAD_F00D, 4'b1111, 32'h0,         "oor_init0");
    req(1'b0, 32'h4,    32'h0,         4'b0000, 32'hDEAD_BEEF, "oor_prime");
    req(1'b0, 32'h1000, 32'h0,         4'b0000, 32'h0,         "oor_read");
    req(1'b1, 32'h1000, 32'h5555_5555, 4'b1111, 32'h0,         "oor_write");
    req(1'b0, 32'h0,    32'h0,         4'b0000, 32'h0BAD_F00D, "oor_word0");
  endtask

  task automatic test_latency4();
    int   a;
    int   nvalid = 0;
    exp_t e;
    sel4 = 1'b1;
    req(1'b1, 32'h20, 32'hCAFE_F00D, 4'b1111, 32'h0, "l4_w20");
    req(1'b1, 32'h24, 32'h1234_5678, 4'b1111, 32'h0, "l4_w24");
    @(posedge clk); #1;
    en = 1'b1; cmd = 1'b0; addr = 32'h20; mask = 4'b1111; wdata = 32'hFFFF_FFFF;
    a = cyc;
    sb.push_back('{1'b1, 32'hCAFE_F00D, a + 4});
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (valid) begin
        nvalid++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL l4_extra: unexpected valid in cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.due || rdata !== e.data) begin
            errors++;
            $display("FAIL l4_read: cycle %0d data %h, required cycle %0d data %h",
                     cyc, rdata, e.due, e.data);
          end
        end
      end
      @(posedge clk); #1;
      case (cyc - a)
        1:       begin en = 1'b0; addr = 32'h24; cmd = 1'b1; end
        2:       en = 1'b1;
        3:       begin en = 1'b0; addr = 32'h0; end
        default: en = 1'b0;
      endcase
    end
    checks++;
    if (nvalid !== 1) begin
      errors++;
      $display("FAIL l4_count: %0d valid pulses, required 1", nvalid);
    end
    sb.delete();
    req(1'b0, 32'h24, 32'h0, 4'b0000, 32'h1234_5678, "l4_r24");
  endtask

  task automatic test_enable_held();
    int   nvalid = 0;
    int   left = 2;
    bit   drop = 1'b0;
    exp_t e;
    sel4 = 1'b1;
    @(posedge clk); #1;
    en = 1'b1; cmd = 1'b0; addr = 32'h20; mask = 4'b0000;
    sb.push_back('{1'b1, 32'hCAFE_F00D, cyc + 4});
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (valid) begin
        nvalid++;
        drop = 1'b1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL held_dup: unexpected valid in cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.due || rdata !== e.data) begin
            errors++;
            $display("FAIL held_read: cycle %0d data %h, required cycle %0d data %h",
                     cyc, rdata, e.due, e.data);
          end
        end
      end
      @(posedge clk); #1;
      if (drop) begin
        en = 1'b0;
        drop = 1'b0;
      end else if (!en && left > 0) begin
        en = 1'b1;
        sb.push_back('{1'b1, 32'hCAFE_F00D, cyc + 4});
        left--;
      end
    end
    en = 1'b0;
    checks++;
    if (nvalid !== 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL held_count: %0d valid, %0d pending, required 3 valid 0 pending",
               nvalid, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    int   c;
    int   nvalid = 0;
    exp_t e;
    sel4 = 1'b0;
    @(posedge clk); #1;
    en = 1'b1; cmd = 1'b0; addr = 32'h4; mask = 4'b0000;
    c = cyc;
    for (int r = 0; r < 4; r++) sb.push_back('{1'b1, 32'hDEAD_BEEF, c + 1 + 2 * r});
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (valid) begin
        nvalid++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: unexpected valid in cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.due || rdata !== e.data) begin
            errors++;
            $display("FAIL b2b_read: cycle %0d data %h, required cycle %0d data %h",
                     cyc, rdata, e.due, e.data);
          end
        end
      end
      @(posedge clk); #1;
      if (cyc == c + 8) en = 1'b0;
    end
    checks++;
    if (nvalid !== 4) begin
      errors++;
      $display("FAIL b2b_count: %0d valid pulses, required 4", nvalid);
    end
    sb.delete();
  endtask

  initial begin
    test_reset_state();
    test_reset_mid_request();
    test_latency1();
    test_byte_mask();
    test_out_of_range();
    test_latency4();
    test_enable_held();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
